load_store_unit: RTL and testbench

Initiator side of the data-memory interface. Accepts one load/store per handshake from the core datapath and decodes RV32I funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW). It issues word-aligned, byte-enabled requests to data memory, splitting misaligned accesses into two word transactions. It returns sign- or zero-extended load data. It sits between the execute stage and the data memory.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_align.sv | 64 ++++++
 rtl/load_store_unit.sv | 209 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared funct3 codes, FSM state type and access-size helpers for
//          the load/store unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_LO = 3'd1,
        WAIT_LO  = 3'd2,
        ISSUE_HI = 3'd3,
        WAIT_HI  = 3'd4,
        RESP     = 3'd5
    } lsu_state_t;

    // Access size in bytes; unknown codes report word size and are
    // screened out by funct3_legal before any access is made.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_of = 3'd1;
            F3_H, F3_HU: size_of = 3'd2;
            default:     size_of = 3'd4;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: funct3_legal = 1'b1;
            F3_BU, F3_HU:     funct3_legal = ~we;
            default:          funct3_legal = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module : lsu_align
// Brief  : Combinational lane logic: byte enables, split detection, store
//          data shift and load data shift/extension.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_lo,
    input  logic [31:0] load_hi,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic        split,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] load_data
);

    logic [3:0]  w_size_mask;
    logic [7:0]  w_mask;
    logic [4:0]  w_shift;
    logic [63:0] w_store_wide;
    logic [63:0] w_load_wide;

    always_comb begin
        case (size_of(funct3))
            3'd1:    w_size_mask = 4'b0001;
            3'd2:    w_size_mask = 4'b0011;
            default: w_size_mask = 4'b1111;
        endcase
    end

    assign w_mask       = {4'b0000, w_size_mask} << offset;
    assign w_shift      = {offset, 3'b000};
    assign be_lo        = w_mask[3:0];
    assign be_hi        = w_mask[7:4];
    assign split        = |w_mask[7:4];

    assign w_store_wide = {32'h0, store_data} << w_shift;
    assign wdata_lo     = w_store_wide[31:0];
    assign wdata_hi     = w_store_wide[63:32];

    // Bytes straddling a word boundary land back in the low lanes here.
    assign w_load_wide  = {load_hi, load_lo} >> w_shift;

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{w_load_wide[7]}}, w_load_wide[7:0]};
            F3_H:    load_data = {{16{w_load_wide[15]}}, w_load_wide[15:0]};
            F3_BU:   load_data = {24'h0, w_load_wide[7:0]};
            F3_HU:   load_data = {16'h0, w_load_wide[15:0]};
            default: load_data = w_load_wide[31:0];
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Brief  : Data-memory initiator: decodes RV32I loads/stores, splits
//          misaligned accesses into two word requests, extends load data.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [31:0]           mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] c_word_step = ADDR_WIDTH'(4);

    lsu_state_t            r_state;
    lsu_state_t            w_state_next;

    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_lo_data;
    logic [31:0]           r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [3:0]            r_mem_be;
    logic [31:0]           r_mem_wdata;

    logic                  w_idle;
    logic                  w_accept;
    logic                  w_sel_we;
    logic [2:0]            w_sel_funct3;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [31:0]           w_sel_wdata;
    logic [ADDR_WIDTH-1:0] w_lo_addr;
    logic [ADDR_WIDTH-1:0] w_hi_addr;
    logic [31:0]           w_lo_word;
    logic [3:0]            w_be_lo;
    logic [3:0]            w_be_hi;
    logic                  w_split;
    logic [31:0]           w_wdata_lo;
    logic [31:0]           w_wdata_hi;
    logic [31:0]           w_load_data;
    logic                  w_bad;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle & req_valid;

    // In IDLE the aligner sees the incoming request so the low-word request
    // can be registered on the accept edge; afterwards it sees the latched copy.
    assign w_sel_we     = w_idle ? req_we     : r_we;
    assign w_sel_funct3 = w_idle ? req_funct3 : r_funct3;
    assign w_sel_addr   = w_idle ? req_addr   : r_addr;
    assign w_sel_wdata  = w_idle ? req_wdata  : r_wdata;

    assign w_lo_addr = {w_sel_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_hi_addr = w_lo_addr + c_word_step;
    assign w_lo_word = (r_state == WAIT_LO) ? mem_rdata : r_lo_data;

    lsu_align u_align (
        .funct3     (w_sel_funct3),
        .offset     (w_sel_addr[1:0]),
        .store_data (w_sel_wdata),
        .load_lo    (w_lo_word),
        .load_hi    (mem_rdata),
        .be_lo      (w_be_lo),
        .be_hi      (w_be_hi),
        .split      (w_split),
        .wdata_lo   (w_wdata_lo),
        .wdata_hi   (w_wdata_hi),
        .load_data  (w_load_data)
    );

    assign w_bad = ~funct3_legal(w_sel_we, w_sel_funct3) | (w_split & ~MISALIGNED_EN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_next = w_bad ? RESP : ISSUE_LO;
                end
            end
            ISSUE_LO: begin
                if (mem_req_ready) begin
                    if (!r_we) begin
                        w_state_next = WAIT_LO;
                    end else begin
                        w_state_next = w_split ? ISSUE_HI : RESP;
                    end
                end
            end
            WAIT_LO: begin
                if (mem_rsp_valid) begin
                    w_state_next = w_split ? ISSUE_HI : RESP;
                end
            end
            ISSUE_HI: begin
                if (mem_req_ready) begin
                    w_state_next = r_we ? RESP : WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (mem_rsp_valid) begin
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        mem_req_valid = 1'b0;
        case (r_state)
            IDLE:               req_ready     = 1'b1;
            ISSUE_LO, ISSUE_HI: mem_req_valid = 1'b1;
            RESP:               rsp_valid     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= '0;
            r_wdata     <= 32'h0;
            r_lo_data   <= 32'h0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0;
        end else begin
            if (w_accept) begin
                r_we        <= req_we;
                r_funct3    <= req_funct3;
                r_addr      <= req_addr;
                r_wdata     <= req_wdata;
                r_rsp_rdata <= 32'h0;
                r_rsp_err   <= w_bad;
                if (!w_bad) begin
                    r_mem_we    <= req_we;
                    r_mem_addr  <= w_lo_addr;
                    r_mem_be    <= w_be_lo;
                    r_mem_wdata <= w_wdata_lo;
                end
            end
            if (w_state_next == ISSUE_HI && r_state != ISSUE_HI) begin
                r_mem_addr  <= w_hi_addr;
                r_mem_be    <= w_be_hi;
                r_mem_wdata <= w_wdata_hi;
            end
            if (r_state == WAIT_LO && mem_rsp_valid) begin
                r_lo_data <= mem_rdata;
            end
            // The final read word is taken straight from the bus on the way to RESP.
            if ((r_state == WAIT_LO || r_state == WAIT_HI) && w_state_next == RESP) begin
                r_rsp_rdata <= w_load_data;
            end
        end
    end

    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Directed and random checks of load_store_unit against a byte-level
//          memory model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    logic        req_ready, rsp_valid, rsp_err, mem_req_valid, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        rej_req_ready, rej_rsp_valid, rej_rsp_err, rej_mem_req_valid, rej_mem_we;
    logic [31:0] rej_rsp_rdata, rej_mem_addr, rej_mem_wdata;
    logic [3:0]  rej_mem_be;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] bmem [logic [31:0]];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32), .MISALIGNED_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.ADDR_WIDTH(32), .MISALIGNED_EN(1'b0)) dut_rej (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(rej_req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rej_rsp_valid), .rsp_rdata(rej_rsp_rdata), .rsp_err(rej_rsp_err),
        .mem_req_valid(rej_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(rej_mem_we),
        .mem_addr(rej_mem_addr), .mem_be(rej_mem_be), .mem_wdata(rej_mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] mword(input logic [31:0] wa);
        return {mbyte(wa + 32'd3), mbyte(wa + 32'd2), mbyte(wa + 32'd1), mbyte(wa)};
    endfunction

    task automatic set_word(input logic [31:0] wa, input logic [31:0] w);
        for (int i = 0; i < 4; i++) bmem[wa + i] = w[i*8 +: 8];
    endtask

    // One complete transaction with a memory responder; the model is built
    // from byte addresses and word grouping, independent of lane shifting.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int stall, input int lat,
                          input bit noise, output logic [31:0] o_rdata, output int o_lat);
        int          n, cnt, issued, wait_cnt, pend, exp_lat;
        bit          legal, acc, done;
        logic [31:0] e_addr [2];
        logic [3:0]  e_be   [2];
        logic [31:0] e_wd   [2];
        logic [63:0] wide;
        logic [31:0] e_rdata, ba, paddr, s_addr, s_wd;
        logic [3:0]  s_be;
        logic        s_we;

        n     = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
        legal = we ? (f3 <= 3'b010) : (f3 <= 3'b010 || f3 == 3'b100 || f3 == 3'b101);
        cnt   = 0;
        e_addr[0] = 0; e_addr[1] = 0; e_be[0] = 0; e_be[1] = 0;
        if (legal) begin
            for (int i = 0; i < n; i++) begin
                ba = addr + i;
                if (cnt == 0 || e_addr[cnt-1] != {ba[31:2], 2'b00}) begin
                    e_addr[cnt] = {ba[31:2], 2'b00};
                    cnt++;
                end
                e_be[cnt-1][ba[1:0]] = 1'b1;
            end
        end
        wide    = {32'h0, wdata} << (8 * addr[1:0]);
        e_wd[0] = wide[31:0];
        e_wd[1] = wide[63:32];
        e_rdata = 32'h0;
        if (legal && !we) begin
            for (int i = 0; i < n; i++) e_rdata[i*8 +: 8] = mbyte(addr + i);
            if (!f3[2] && n < 4 && e_rdata[8*n-1]) e_rdata = e_rdata | ~((32'h1 << (8*n)) - 32'h1);
        end
        exp_lat = 1 + cnt * (stall + 1) + (we ? 0 : cnt * lat);

        check("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        issued = 0; wait_cnt = 0; pend = 0; acc = 0; done = 0;
        o_lat = 0; o_rdata = 32'h0; paddr = 0;
        s_addr = 0; s_be = 0; s_we = 0; s_wd = 0;
        for (int c = 1; c <= 200 && !done; c++) begin
            if (acc) begin
                acc = 0; issued++;
                if (!we) begin pend = lat; paddr = s_addr; end
            end
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin mem_rsp_valid = 1'b1; mem_rdata = mword(paddr); end
            end else if (noise && $urandom_range(0, 3) == 0) begin
                mem_rsp_valid = 1'b1; mem_rdata = $urandom;
            end
            if (rsp_valid) begin
                done = 1; o_lat = c; o_rdata = rsp_rdata;
            end else if (mem_req_valid) begin
                if (wait_cnt == 0) begin
                    check("mem_req_expected", issued < cnt, 1'b1);
                    if (issued < cnt) begin
                        check("mem_addr", mem_addr, e_addr[issued]);
                        check("mem_be", mem_be, e_be[issued]);
                        check("mem_we", mem_we, we);
                        if (we) check("mem_wdata", mem_wdata, e_wd[issued]);
                    end
                    s_addr = mem_addr; s_be = mem_be; s_we = mem_we; s_wd = mem_wdata;
                end else begin
                    check("mem_stable", {mem_addr, mem_be, mem_we, mem_wdata}, {s_addr, s_be, s_we, s_wd});
                end
                wait_cnt++;
                if (wait_cnt > stall) begin mem_req_ready = 1'b1; acc = 1; wait_cnt = 0; end
            end
            if (!done) @(negedge clk);
        end
        check("rsp_timeout", done, 1'b1);
        check("rsp_err", rsp_err, !legal);
        check("rsp_rdata", rsp_rdata, e_rdata);
        check("mem_req_count", issued, cnt);
        check("latency", o_lat, exp_lat);
        if (legal && we) for (int i = 0; i < n; i++) bmem[addr + i] = wdata[i*8 +: 8];
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        check("rsp_one_cycle", rsp_valid, 1'b0);
        check("rsp_rdata_hold", rsp_rdata, e_rdata);
    endtask

    initial begin
        logic [31:0] rd;
        int          lt;
        logic [2:0]  legal_f3 [8];

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_mem_fields", {mem_we, mem_addr, mem_be, mem_wdata}, 69'h0);

        // Misaligned word on the rejecting instance: error response, no access.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h101;
        @(negedge clk);
        req_valid = 1'b0;
        check("rej_rsp_valid", rej_rsp_valid, 1'b1);
        check("rej_rsp_err", rej_rsp_err, 1'b1);
        check("rej_rsp_rdata", rej_rsp_rdata, 32'h0);
        check("rej_no_mem_req", rej_mem_req_valid, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 1'b0, rd, lt);
        check("sw_latency", lt, 2);

        set_word(32'h100, 32'h80123456);
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 0, 1, 1'b0, rd, lt);
        check("lb_rdata", rd, 32'hFFFFFF80);
        check("lb_latency", lt, 3);
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 0, 1, 1'b0, rd, lt);
        check("lbu_rdata", rd, 32'h00000080);

        set_word(32'h100, 32'hABCD0000);
        run_op(1'b0, 3'b101, 32'h102, 32'h0, 0, 1, 1'b0, rd, lt);
        check("lhu_rdata", rd, 32'h0000ABCD);

        set_word(32'h100, 32'h11223344);
        set_word(32'h104, 32'h55667788);
        run_op(1'b0, 3'b010, 32'h102, 32'h0, 0, 1, 1'b0, rd, lt);
        check("split_lw_rdata", rd, 32'h77881122);
        check("split_lw_latency", lt, 5);

        run_op(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF, 0, 1, 1'b0, rd, lt);
        check("wrap_sh_byte_hi", mbyte(32'h0), 8'hBE);

        run_op(1'b0, 3'b011, 32'h100, 32'h0, 0, 1, 1'b0, rd, lt);
        check("illegal_latency", lt, 1);
        check("illegal_rdata", rd, 32'h0);

        run_op(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 5, 1, 1'b0, rd, lt);
        check("stall_latency", lt, 7);

        // Reset while waiting for read data; the late response must be dropped.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
        @(negedge clk);
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_mem_req_valid", mem_req_valid, 1'b0);
        check("midrst_req_ready", req_ready, 1'b1);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_fields", {mem_addr, mem_be, rsp_rdata}, 68'h0);
        mem_rsp_valid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("late_rsp_ignored", rsp_valid, 1'b0);
        check("late_rsp_idle", req_ready, 1'b1);
        @(negedge clk);
        check("late_rsp_no_resp", rsp_valid, 1'b0);

        legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010; legal_f3[3] = 3'b100;
        legal_f3[4] = 3'b101; legal_f3[5] = 3'b010; legal_f3[6] = 3'b000; legal_f3[7] = 3'b001;
        for (int k = 0; k < 200; k++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a;
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 7)];
            a  = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF8 + $urandom_range(0, 7))
                                             : (32'h300 + $urandom_range(0, 63));
            run_op(we, f3, a, $urandom, $urandom_range(0, 2), $urandom_range(1, 3), 1'b1, rd, lt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
